cache_fill_sequencer: RTL

Parametrised successor to the fixed 3-to-8 word and 7-to-128 set one-hot decoders in the cache datapath.
- While idle, it decodes the access address into one-hot set and word enables.
- On a miss, it takes over the cache array and runs a block fill: it issues pipelined word reads to memory and steers each returned word into the array with the correct set and word enables.
- It writes the tag on the last returned word and pulses completion.
- It sits between the cache control FSM, the tag/data arrays and the 4-cycle pipelined main memory.

---
 rtl/cache_pkg.sv | 30 +++
 rtl/cache_fill_sequencer_if.sv | 19 +
 rtl/onehot_decoder.sv | 10 +
 rtl/cache_fill_sequencer.sv | 94 +++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// cache_pkg: geometry, fill FSM states and address field helpers for the cache fill sequencer
package cache_pkg;
  localparam int ADDR_W     = 16;
  localparam int BYTE_W     = 1;
  localparam int WORD_SEL_W = 3;
  localparam int SET_W      = 7;
  localparam int WORDS      = 2 ** WORD_SEL_W;
  localparam int SETS       = 2 ** SET_W;
  localparam int CNT_W      = WORD_SEL_W + 1;
  localparam int WORD_LSB   = BYTE_W;
  localparam int SET_LSB    = BYTE_W + WORD_SEL_W;
  typedef enum logic [1:0] {IDLE, FILL, DONE} fill_state_t;
  function automatic logic [SET_W-1:0] addr_set(input logic [ADDR_W-1:0] a);
    return a[SET_LSB +: SET_W];
  endfunction
  function automatic logic [WORD_SEL_W-1:0] addr_word(input logic [ADDR_W-1:0] a);
    return a[WORD_LSB +: WORD_SEL_W];
  endfunction
  function automatic logic [ADDR_W-1:0] with_word(input logic [ADDR_W-1:0] a,
                                                  input logic [WORD_SEL_W-1:0] w);
    logic [ADDR_W-1:0] r;
    r = a;
    r[WORD_LSB +: WORD_SEL_W] = w;
    r[BYTE_W-1:0] = '0;
    return r;
  endfunction
  function automatic logic [ADDR_W-1:0] block_base(input logic [ADDR_W-1:0] a);
    return with_word(a, '0);
  endfunction
endpackage

// File: rtl/cache_fill_sequencer_if.sv
// cache_fill_if: CPU access, memory read and cache array enable signals of the fill sequencer
interface cache_fill_if;
  import cache_pkg::*;
  logic [ADDR_W-1:0] addr;
  logic              miss;
  logic              mem_valid;
  logic [SETS-1:0]   set_en;
  logic [WORDS-1:0]  word_en;
  logic              data_we;
  logic              tag_we;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              busy;
  logic              fill_done;
  modport master (output addr, miss, mem_valid,
                  input  set_en, word_en, data_we, tag_we, mem_req, mem_addr, busy, fill_done);
  modport slave  (input  addr, miss, mem_valid,
                  output set_en, word_en, data_we, tag_we, mem_req, mem_addr, busy, fill_done);
endinterface

// File: rtl/onehot_decoder.sv
// onehot_decoder: binary select to one-hot enable vector
module onehot_decoder #(
  parameter int IN_W = 3
) (
  input  logic [IN_W-1:0]      sel_i,
  output logic [2**IN_W-1:0]   onehot_o
);
  localparam int N = 2 ** IN_W;
  assign onehot_o = N'(1) << sel_i;
endmodule

// File: rtl/cache_fill_sequencer.sv
// cache_fill_sequencer: idle set/word decode, pipelined block fill from memory, tag write and done pulse
module cache_fill_sequencer
  import cache_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  cache_fill_if.slave  bus
);
  fill_state_t           state_q, state_d;
  logic [CNT_W-1:0]      issue_q, issue_d, recv_q, recv_d;
  logic [ADDR_W-1:0]     base_q, base_d;
  logic [WORD_SEL_W-1:0] word_q, word_d;
  logic [SET_W-1:0]      set_sel;
  logic [WORD_SEL_W-1:0] word_sel;
  logic [WORDS-1:0]      word_dec;
  logic                  word_on, req, rx;
  onehot_decoder #(.IN_W(SET_W))      u_set_dec  (.sel_i(set_sel),  .onehot_o(bus.set_en));
  onehot_decoder #(.IN_W(WORD_SEL_W)) u_word_dec (.sel_i(word_sel), .onehot_o(word_dec));
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      issue_q <= '0;
      recv_q  <= '0;
      base_q  <= '0;
      word_q  <= '0;
    end else begin
      state_q <= state_d;
      issue_q <= issue_d;
      recv_q  <= recv_d;
      base_q  <= base_d;
      word_q  <= word_d;
    end
  end
  always_comb begin
    state_d       = state_q;
    issue_d       = issue_q;
    recv_d        = recv_q;
    base_d        = base_q;
    word_d        = word_q;
    set_sel       = addr_set(bus.addr);
    word_sel      = addr_word(bus.addr);
    word_on       = 1'b0;
    req           = 1'b0;
    rx            = 1'b0;
    bus.data_we   = 1'b0;
    bus.tag_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.busy      = 1'b0;
    bus.fill_done = 1'b0;
    unique case (state_q)
      IDLE: begin
        bus.busy = bus.miss;
        word_on  = 1'b1;
        if (bus.miss) begin
          base_d  = block_base(bus.addr);
          word_d  = addr_word(bus.addr);
          issue_d = '0;
          recv_d  = '0;
          state_d = FILL;
        end
      end
      FILL: begin
        bus.busy     = 1'b1;
        set_sel      = addr_set(base_q);
        req          = issue_q < CNT_W'(WORDS);
        bus.mem_addr = req ? with_word(base_q, issue_q[WORD_SEL_W-1:0]) : base_q;
        issue_d      = issue_q + CNT_W'(req);
        // a return only counts against a request already issued in an earlier cycle
        rx           = bus.mem_valid && (recv_q < issue_q);
        word_sel     = recv_q[WORD_SEL_W-1:0];
        word_on      = rx;
        bus.data_we  = rx;
        recv_d       = recv_q + CNT_W'(rx);
        if (rx && recv_q == CNT_W'(WORDS - 1)) begin
          bus.tag_we = 1'b1;
          state_d    = DONE;
        end
      end
      DONE: begin
        bus.busy      = 1'b1;
        bus.fill_done = 1'b1;
        set_sel       = addr_set(base_q);
        word_sel      = word_q;
        word_on       = 1'b1;
        bus.mem_addr  = base_q;
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  assign bus.mem_req = req;
  // word enables are forced off while reset is held, even though IDLE decodes addr
  assign bus.word_en = (word_on && rst_n) ? word_dec : '0;
endmodule
